i2s_tx_sched: RTL

Stereo sample scheduler in front of the I2S transmitter. It accepts left/right sample pairs from a valid/ready stream and buffers one pair. It presents `left_data`/`right_data` to the transmitter, timed so each word is stable for at least a full half-frame before the transmitter loads it. It detects and counts underruns and sequences enable/disable on frame boundaries. It sits between the audio source (FIFO/DSP) and the `i2s_clkgen` + `i2s_tx` pair, in the same `clk` domain.

---
 rtl/i2s_tx_sched.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/i2s_tx_sched.sv
// i2s_tx_sched: stereo sample scheduler in front of an I2S transmitter.
//
// Accepts left/right pairs on a valid/ready stream into a one-pair buffer,
// pops the buffer at the start of each right half-frame, and presents
// left_data / right_data so each word is stable for a full half-frame
// before the transmitter loads it. Counts underruns (saturating), and
// starts and stops only on left-half (frame) boundaries.
//
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   enable              run request
//   lrclk               word select from clkgen (0 = left half, 1 = right half)
//   s_valid/s_ready     input pair handshake
//   s_left/s_right      input pair
//   left_data           to tx left input  (updates only at right-half start)
//   right_data          to tx right input (updates only at left-half start)
//   running             high in RUN
//   underrun            one-cycle pulse per underrun frame
//   underrun_count      saturating underrun total
module i2s_tx_sched #(
  parameter int unsigned DATA_BITS     = 24,
  parameter bit          UNDERRUN_MUTE = 1'b0,
  parameter int unsigned CNT_BITS      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 lrclk,
  input  logic                 s_valid,
  input  logic [DATA_BITS-1:0] s_left,
  input  logic [DATA_BITS-1:0] s_right,
  output logic                 s_ready,
  output logic [DATA_BITS-1:0] left_data,
  output logic [DATA_BITS-1:0] right_data,
  output logic                 running,
  output logic                 underrun,
  output logic [CNT_BITS-1:0]  underrun_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic                 lrclk_q;
  logic                 tick_r_q, tick_r_d;
  logic                 tick_l_q, tick_l_d;
  logic [DATA_BITS-1:0] sbuf_l_q, sbuf_l_d;
  logic [DATA_BITS-1:0] sbuf_r_q, sbuf_r_d;
  logic                 sbuf_full_q, sbuf_full_d;
  logic [DATA_BITS-1:0] hold_l_q, hold_l_d;
  logic [DATA_BITS-1:0] hold_r_q, hold_r_d;
  logic [DATA_BITS-1:0] left_q, left_d;
  logic [DATA_BITS-1:0] right_q, right_d;
  logic                 underrun_q, underrun_d;
  logic [CNT_BITS-1:0]  cnt_q, cnt_d;
  logic                 run_w;
  logic                 accept_w;

  assign run_w    = (state_q == RUN);
  assign accept_w = s_valid & run_w & ~sbuf_full_q;

  assign s_ready        = run_w & ~sbuf_full_q;
  assign running        = run_w;
  assign left_data      = left_q;
  assign right_data     = right_q;
  assign underrun       = underrun_q;
  assign underrun_count = cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      lrclk_q     <= 1'b0;
      tick_r_q    <= 1'b0;
      tick_l_q    <= 1'b0;
      sbuf_l_q    <= '0;
      sbuf_r_q    <= '0;
      sbuf_full_q <= 1'b0;
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      left_q      <= '0;
      right_q     <= '0;
      underrun_q  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      lrclk_q     <= lrclk;
      tick_r_q    <= tick_r_d;
      tick_l_q    <= tick_l_d;
      sbuf_l_q    <= sbuf_l_d;
      sbuf_r_q    <= sbuf_r_d;
      sbuf_full_q <= sbuf_full_d;
      hold_l_q    <= hold_l_d;
      hold_r_q    <= hold_r_d;
      left_q      <= left_d;
      right_q     <= right_d;
      underrun_q  <= underrun_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    // Ticks are registered so they land one clk after the lrclk edge and
    // the data registers move one clk after that.
    tick_r_d    = lrclk & ~lrclk_q;
    tick_l_d    = ~lrclk & lrclk_q;
    state_d     = state_q;
    sbuf_l_d    = sbuf_l_q;
    sbuf_r_d    = sbuf_r_q;
    sbuf_full_d = sbuf_full_q;
    hold_l_d    = hold_l_q;
    hold_r_d    = hold_r_q;
    left_d      = left_q;
    right_d     = right_q;
    underrun_d  = 1'b0;
    cnt_d       = cnt_q;

    case (state_q)
      IDLE: begin
        sbuf_full_d = 1'b0;
        hold_l_d    = '0;
        hold_r_d    = '0;
        left_d      = '0;
        right_d     = '0;
        if (enable) state_d = SYNC;
      end

      SYNC: begin
        if (!enable)       state_d = IDLE;
        else if (tick_l_q) state_d = RUN;
      end

      RUN: begin
        // s_ready is low while full, so an accept never meets a pop.
        if (accept_w) begin
          sbuf_l_d    = s_left;
          sbuf_r_d    = s_right;
          sbuf_full_d = 1'b1;
        end

        if (tick_r_q) begin
          if (sbuf_full_q) begin
            hold_l_d    = sbuf_l_q;
            hold_r_d    = sbuf_r_q;
            sbuf_full_d = 1'b0;
            left_d      = sbuf_l_q;
          end else begin
            underrun_d = 1'b1;
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
            if (UNDERRUN_MUTE) begin
              hold_l_d = '0;
              hold_r_d = '0;
              left_d   = '0;
            end
          end
        end

        if (tick_l_q) begin
          if (!enable) begin
            // Shutdown clear comes last so a same-cycle accept cannot leave
            // a stale pair in the buffer while IDLE.
            state_d     = IDLE;
            sbuf_full_d = 1'b0;
            hold_l_d    = '0;
            hold_r_d    = '0;
            left_d      = '0;
            right_d     = '0;
          end else begin
            right_d = hold_r_q;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule
